// File: rtl/vga_pkg.sv
// Shared VGA timing types, standard mode constants, test-pattern select encoding
// and the colour-bar index helper used by vga_timing_gen and vga_pattern_gen.
package vga_pkg;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } vga_axis_t;

    typedef struct packed {
        vga_axis_t h;
        vga_axis_t v;
    } vga_mode_t;

    localparam vga_mode_t VGA_640X480_60 = '{
        h: '{active: 16'd640,  fp: 16'd16, sync: 16'd96,  bp: 16'd48},
        v: '{active: 16'd480,  fp: 16'd10, sync: 16'd2,   bp: 16'd33}
    };
    localparam vga_mode_t VGA_800X600_60 = '{
        h: '{active: 16'd800,  fp: 16'd40, sync: 16'd128, bp: 16'd88},
        v: '{active: 16'd600,  fp: 16'd1,  sync: 16'd4,   bp: 16'd23}
    };
    localparam vga_mode_t VGA_1024X768_60 = '{
        h: '{active: 16'd1024, fp: 16'd24, sync: 16'd136, bp: 16'd160},
        v: '{active: 16'd768,  fp: 16'd3,  sync: 16'd6,   bp: 16'd29}
    };

    typedef enum logic [1:0] {
        PAT_EXT     = 2'd0,
        PAT_BARS    = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_RAMP    = 2'd3
    } vga_pat_e;

    // Eight equal-width vertical bars across the visible line.
    function automatic logic [2:0] bar_index(input int unsigned x, input int unsigned h_active);
        return 3'((x * 32'd8) / h_active);
    endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// Built-in test pattern source, present only when VGA_TEST_PATTERN_EN is defined.
// One register stage, so it stands in exactly for an external one-step-latency renderer.
`ifdef VGA_TEST_PATTERN_EN
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned HW       = 10,
    parameter int unsigned VW       = 10,
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned COLOR_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic [HW-1:0]      x,
    input  logic [VW-1:0]      y,
    input  vga_pat_e           sel,
    output logic               pat_on,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b
);

    logic [2:0]         bar;
    logic               checker_bit;
    logic [COLOR_W-1:0] ramp;
    logic [COLOR_W-1:0] nr, ng, nb;

    // Shifting in 32 bits keeps x[4]/y[4] well defined even for counters narrower than 5 bits.
    assign bar         = bar_index(32'(x), H_ACTIVE);
    assign checker_bit = 1'(32'(x) >> 4) ^ 1'(32'(y) >> 4);
    assign ramp        = COLOR_W'((32'(x) << COLOR_W) >> HW);

    always_comb begin
        nr = '0;
        ng = '0;
        nb = '0;
        unique case (sel)
            PAT_BARS: begin
                nr = {COLOR_W{bar[2]}};
                ng = {COLOR_W{bar[1]}};
                nb = {COLOR_W{bar[0]}};
            end
            PAT_CHECKER: begin
                nr = {COLOR_W{checker_bit}};
                ng = {COLOR_W{checker_bit}};
                nb = {COLOR_W{checker_bit}};
            end
            PAT_RAMP: begin
                nr = ramp;
                ng = ramp;
                nb = ramp;
            end
            default: begin
                nr = '0;
                ng = '0;
                nb = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_on <= 1'b0;
            r      <= '0;
            g      <= '0;
            b      <= '0;
        end else if (ce) begin
            pat_on <= (sel != PAT_EXT);
            r      <= nr;
            g      <= ng;
            b      <= nb;
        end
    end

endmodule
`endif

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with a 2-step pixel pipeline aligning sync/de/rgb.
// Defining VGA_TEST_PATTERN_EN adds i_pat_sel and the vga_pattern_gen source.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 23,
    parameter bit          H_POL    = 1'b1,
    parameter bit          V_POL    = 1'b1,
    parameter int unsigned COLOR_W  = 4,
    localparam int unsigned H_TOT   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOT   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW      = $clog2(H_TOT),
    localparam int unsigned VW      = $clog2(V_TOT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_pix_ce,
    input  logic [COLOR_W-1:0] i_r,
    input  logic [COLOR_W-1:0] i_g,
    input  logic [COLOR_W-1:0] i_b,
`ifdef VGA_TEST_PATTERN_EN
    input  logic [1:0]         i_pat_sel,
`endif
    output logic [HW-1:0]      o_x,
    output logic [VW-1:0]      o_y,
    output logic               o_req,
    output logic               o_frame_start,
    output logic               o_h_sync,
    output logic               o_v_sync,
    output logic               o_de,
    output logic [COLOR_W-1:0] o_r,
    output logic [COLOR_W-1:0] o_g,
    output logic [COLOR_W-1:0] o_b
);

    localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END = H_SYNC_BEG + H_SYNC;
    localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END = V_SYNC_BEG + V_SYNC;
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);

    // Stage 0: position counters.
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    // i_pix_ce is a strobe, not a handshake: every register advances one pixel when it is
    // high and holds when it is low; the renderer has no way to stall the raster.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (i_pix_ce) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

    logic act_s0;
    logic hs_s0;
    logic vs_s0;

    assign act_s0 = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
    assign hs_s0  = (32'(h_cnt) >= H_SYNC_BEG) && (32'(h_cnt) < H_SYNC_END);
    assign vs_s0  = (32'(v_cnt) >= V_SYNC_BEG) && (32'(v_cnt) < V_SYNC_END);

    // Pixel source presented during stage 1 (one step after the request).
    logic [COLOR_W-1:0] src_r;
    logic [COLOR_W-1:0] src_g;
    logic [COLOR_W-1:0] src_b;

`ifdef VGA_TEST_PATTERN_EN
    logic               pat_on;
    logic [COLOR_W-1:0] pat_r;
    logic [COLOR_W-1:0] pat_g;
    logic [COLOR_W-1:0] pat_b;

    vga_pattern_gen #(
        .HW       (HW),
        .VW       (VW),
        .H_ACTIVE (H_ACTIVE),
        .COLOR_W  (COLOR_W)
    ) u_pattern_gen (
        .clk    (clk),
        .reset  (reset),
        .ce     (i_pix_ce),
        .x      (h_cnt),
        .y      (v_cnt),
        .sel    (vga_pat_e'(i_pat_sel)),
        .pat_on (pat_on),
        .r      (pat_r),
        .g      (pat_g),
        .b      (pat_b)
    );

    assign src_r = pat_on ? pat_r : i_r;
    assign src_g = pat_on ? pat_g : i_g;
    assign src_b = pat_on ? pat_b : i_b;
`else
    assign src_r = i_r;
    assign src_g = i_g;
    assign src_b = i_b;
`endif

    // Stage 1 / stage 2 control shift and output pixel register.
    logic               de_q1, hs_q1, vs_q1;
    logic               de_q2, hs_q2, vs_q2;
    logic [COLOR_W-1:0] r_q2, g_q2, b_q2;

    always_ff @(posedge clk) begin
        if (reset) begin
            de_q1 <= 1'b0;
            hs_q1 <= 1'b0;
            vs_q1 <= 1'b0;
            de_q2 <= 1'b0;
            hs_q2 <= 1'b0;
            vs_q2 <= 1'b0;
            r_q2  <= '0;
            g_q2  <= '0;
            b_q2  <= '0;
        end else if (i_pix_ce) begin
            de_q1 <= act_s0;
            hs_q1 <= hs_s0;
            vs_q1 <= vs_s0;
            de_q2 <= de_q1;
            hs_q2 <= hs_q1;
            vs_q2 <= vs_q1;
            r_q2  <= de_q1 ? src_r : '0;
            g_q2  <= de_q1 ? src_g : '0;
            b_q2  <= de_q1 ? src_b : '0;
        end
    end

    // Outputs are also gated by reset itself so the cycle in which reset is first seen
    // already shows idle syncs and blanked video, before the flush edge lands.
    assign o_x           = h_cnt;
    assign o_y           = v_cnt;
    assign o_req         = act_s0 && !reset;
    assign o_frame_start = i_pix_ce && !reset && (h_cnt == '0) && (v_cnt == '0);
    assign o_de          = de_q2 && !reset;
    assign o_h_sync      = (hs_q2 && !reset) ? H_POL : !H_POL;
    assign o_v_sync      = (vs_q2 && !reset) ? V_POL : !V_POL;
    assign o_r           = reset ? '0 : r_q2;
    assign o_g           = reset ? '0 : g_q2;
    assign o_b           = reset ? '0 : b_q2;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen at 8/2/2/2 x 4/1/1/1; one instance per sync polarity.
// Pattern-source steps run only when VGA_TEST_PATTERN_EN is defined.
module tb_vga_timing_gen;

    localparam int HT = 14;
    localparam int FT = 98;

    logic       clk;
    logic       reset;
    logic       i_pix_ce;
    logic [3:0] i_r, i_g, i_b;
`ifdef VGA_TEST_PATTERN_EN
    logic [1:0] i_pat_sel;
`endif

    logic [3:0] o_x,  x_n;
    logic [2:0] o_y,  y_n;
    logic       o_req, req_n, o_frame_start, fs_n;
    logic       o_h_sync, hs_n, o_v_sync, vs_n, o_de, de_n;
    logic [3:0] o_r, o_g, o_b, r_n, g_n, b_n;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .COLOR_W(4)
    ) dut (
        .clk(clk), .reset(reset), .i_pix_ce(i_pix_ce),
        .i_r(i_r), .i_g(i_g), .i_b(i_b),
`ifdef VGA_TEST_PATTERN_EN
        .i_pat_sel(i_pat_sel),
`endif
        .o_x(o_x), .o_y(o_y), .o_req(o_req), .o_frame_start(o_frame_start),
        .o_h_sync(o_h_sync), .o_v_sync(o_v_sync), .o_de(o_de),
        .o_r(o_r), .o_g(o_g), .o_b(o_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0), .COLOR_W(4)
    ) dut_n (
        .clk(clk), .reset(reset), .i_pix_ce(i_pix_ce),
        .i_r(i_r), .i_g(i_g), .i_b(i_b),
`ifdef VGA_TEST_PATTERN_EN
        .i_pat_sel(i_pat_sel),
`endif
        .o_x(x_n), .o_y(y_n), .o_req(req_n), .o_frame_start(fs_n),
        .o_h_sync(hs_n), .o_v_sync(vs_n), .o_de(de_n),
        .o_r(r_n), .o_g(g_n), .o_b(b_n)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench state: k = pix_ce edges since reset release, rend = renderer register
    int          k = 0, rst_run = 0, step_no = 0;
    int          n_assert = 0, n_fail = 0, fs_seen = 0, de_seen = 0;
    bit          fresh = 1'b0;
    int          pat_mode = 0;
    logic [11:0] rend = '0;
    logic [11:0] exp_q[$];

    int          e_x, e_y;
    bit          e_req, e_fs, e_de, e_hact, e_vact, e_chk_xy;
    logic [11:0] e_rgb = '0;

    // Hand-derived timing: H_TOT 14, V_TOT 7, hsync h=10..11, vsync v=5
    function automatic int hpos(input int kk); return (kk % FT) % HT; endfunction
    function automatic int vpos(input int kk); return (kk % FT) / HT; endfunction
    function automatic bit act(input int kk); return (hpos(kk) < 8) && (vpos(kk) < 4); endfunction
    function automatic bit hs_win(input int kk); return (hpos(kk) >= 10) && (hpos(kk) <= 11); endfunction
    function automatic bit vs_win(input int kk); return vpos(kk) == 5; endfunction

    function automatic logic [11:0] ext_pix(input int kk);
        logic [3:0] x, y;
        x = 4'(hpos(kk));
        y = 4'(vpos(kk));
        return {x, y, x ^ y};
    endfunction

    function automatic logic [11:0] exp_pix(input int kk);
        logic [3:0] x;
        x = 4'(hpos(kk));
        if (pat_mode == 1) return {{4{x[2]}}, {4{x[1]}}, {4{x[0]}}};
        return ext_pix(kk);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s step %0d: observed %0h expected %0h", tag, step_no, obs, exp);
        end
    endtask

    task automatic check_inst(input string who, input bit pol,
                              input logic [3:0] x, input logic [2:0] y,
                              input logic req, input logic fs, input logic hs,
                              input logic vs, input logic de,
                              input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        if (e_chk_xy) begin
            chk({who, ".x"}, 32'(x), 32'(e_x));
            chk({who, ".y"}, 32'(y), 32'(e_y));
        end
        chk({who, ".req"},   32'(req), 32'(e_req));
        chk({who, ".fs"},    32'(fs),  32'(e_fs));
        chk({who, ".hsync"}, 32'(hs),  32'(e_hact ? pol : !pol));
        chk({who, ".vsync"}, 32'(vs),  32'(e_vact ? pol : !pol));
        chk({who, ".de"},    32'(de),  32'(e_de));
        chk({who, ".rgb"},   32'({r, g, b}), 32'(e_rgb));
    endtask

    // Driver: one clock with the given ce/reset, checks before the edge, model update after
    task automatic cycle(input bit ce, input bit rst);
        i_pix_ce = ce;
        reset    = rst;
        {i_r, i_g, i_b} = rend;
`ifdef VGA_TEST_PATTERN_EN
        i_pat_sel = 2'(pat_mode);
`endif
        #1;
        e_chk_xy = !rst || (rst_run > 0);
        if (rst) begin
            e_x = 0; e_y = 0; e_req = 0; e_fs = 0;
            e_de = 0; e_hact = 0; e_vact = 0; e_rgb = '0;
        end else begin
            e_x   = hpos(k);
            e_y   = vpos(k);
            e_req = act(k);
            e_fs  = ((k % FT) == 0) && ce;
            if (k >= 2) begin
                e_de = act(k - 2); e_hact = hs_win(k - 2); e_vact = vs_win(k - 2);
            end else begin
                e_de = 0; e_hact = 0; e_vact = 0;
            end
            if (!e_de) begin
                e_rgb = '0;
            end else if (fresh) begin
                n_assert++;
                assert (exp_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL sb_empty step %0d: observed depth %0d expected >0", step_no, exp_q.size());
                end
                if (exp_q.size() > 0) e_rgb = exp_q.pop_front();
            end
        end
        check_inst("p1", 1'b1, o_x, o_y, o_req, o_frame_start, o_h_sync, o_v_sync, o_de, o_r, o_g, o_b);
        check_inst("p0", 1'b0, x_n, y_n, req_n, fs_n, hs_n, vs_n, de_n, r_n, g_n, b_n);
        if (!rst) begin
            if (o_frame_start === 1'b1) fs_seen++;
            if (o_de === 1'b1 && fresh) de_seen++;
        end
        @(posedge clk);
        #1;
        step_no++;
        if (rst) begin
            k = 0; rst_run++; fresh = 1'b0; exp_q.delete();
        end else begin
            rst_run = 0;
            if (ce) begin
                if (act(k)) exp_q.push_back(exp_pix(k));
                rend  = ext_pix(k);
                k++;
                fresh = 1'b1;
            end else begin
                fresh = 1'b0;
            end
        end
    endtask

    initial begin
        i_pix_ce = 1'b0;
        reset    = 1'b1;
        {i_r, i_g, i_b} = '0;
`ifdef VGA_TEST_PATTERN_EN
        i_pat_sel = 2'd0;
`endif

        // Free run 3 frames with the one-step-late renderer
        repeat (3) cycle(1'b1, 1'b1);
        fs_seen = 0; de_seen = 0;
        repeat (3 * FT) cycle(1'b1, 1'b0);
        chk("frame_starts_3f", 32'(fs_seen), 32'd3);
        chk("de_pixels_3f",    32'(de_seen), 32'd96);

        // Pixel enable toggling 1/0: same sequence stretched x2
        repeat (3) cycle(1'b1, 1'b1);
        fs_seen = 0; de_seen = 0;
        for (int i = 0; i < FT; i++) begin
            cycle(1'b1, 1'b0);
            cycle(1'b0, 1'b0);
        end
        chk("frame_starts_ce", 32'(fs_seen), 32'd1);
        chk("de_pixels_ce",    32'(de_seen), 32'd32);

        // Reset mid-frame at h=5, v=2 for 3 cycles
        repeat (3) cycle(1'b1, 1'b1);
        repeat (33) cycle(1'b1, 1'b0);
        chk("mid_x", 32'(o_x), 32'd5);
        chk("mid_y", 32'(o_y), 32'd2);
        repeat (3) cycle(1'b1, 1'b1);
        fs_seen = 0;
        cycle(1'b1, 1'b0);
        chk("fs_after_rst", 32'(fs_seen), 32'd1);
        repeat (FT) cycle(1'b1, 1'b0);

`ifdef VGA_TEST_PATTERN_EN
        // Colour bars, then back to the external path
        pat_mode = 1;
        repeat (3) cycle(1'b1, 1'b1);
        repeat (FT + 2) cycle(1'b1, 1'b0);
        pat_mode = 0;
        repeat (3) cycle(1'b1, 1'b1);
        repeat (FT + 2) cycle(1'b1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
